// File: rtl/line_window_3x3.sv
// line_window_3x3: builds a 3x3 pixel neighbourhood from a raster-order stream
// using two line delays and a register window. The window is centred on
// (r-1,c-1) of the pixel just accepted.
// Optional feature: define WIN_COORD_EN to add col_out/row_out, the
// window-centre coordinates registered alongside win_valid.
module line_window_3x3 #(
  parameter int NUM_BITS   = 8,
  parameter int LINE_WIDTH = 320,
  parameter int NUM_LINES  = 240,
  parameter int COL_BITS   = 9,
  parameter int ROW_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_valid,
  input  logic                    sof,
  input  logic [NUM_BITS-1:0]     pix_in,
  output logic                    win_valid,
  output logic [9*NUM_BITS-1:0]   win_out,
  output logic                    frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [COL_BITS-1:0]     col_out,
  output logic [ROW_BITS-1:0]     row_out
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(LINE_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NUM_LINES - 1);

  logic [1:0]          state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                win_valid_q, win_valid_d;
  logic                done_arm_q, done_arm_d;
  logic                frame_done_q, frame_done_d;
  logic [NUM_BITS-1:0] win_q [9];
  logic [NUM_BITS-1:0] win_d [9];

  // Line delays: line1 holds the previous row, line2 the row before that.
  // Deliberately not reset; FILL gating keeps stale entries out of windows.
  logic [NUM_BITS-1:0] line1_mem [LINE_WIDTH];
  logic [NUM_BITS-1:0] line2_mem [LINE_WIDTH];

  logic                restart;
  logic                accept;
  logic [COL_BITS-1:0] pix_col;
  logic [ROW_BITS-1:0] pix_row;
  logic [NUM_BITS-1:0] tap1;
  logic [NUM_BITS-1:0] tap2;

  // A sof pixel is always (0,0), whatever the counters currently say.
  assign restart = pix_valid & sof;
  assign accept  = pix_valid & (sof | (state_q != ST_IDLE));
  assign pix_col = restart ? '0 : col_q;
  assign pix_row = restart ? '0 : row_q;
  assign tap1    = line1_mem[pix_col];
  assign tap2    = line2_mem[pix_col];

  // Next-state: counters, frame FSM, window shift and output strobes.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    done_arm_d   = 1'b0;
    frame_done_d = done_arm_q;
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      win_valid_d = (pix_row >= ROW_BITS'(2)) && (pix_col >= COL_BITS'(2));
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = pix_row + ROW_BITS'(1);
      end else begin
        col_d = pix_col + COL_BITS'(1);
        row_d = pix_row;
      end
      if (restart) begin
        state_d = ST_FILL;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (pix_row == ROW_BITS'(1) && pix_col == COL_LAST) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (pix_row == ROW_LAST && pix_col == COL_LAST) begin
              state_d    = ST_IDLE;
              col_d      = '0;
              row_d      = '0;
              done_arm_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Shift every row one column left; the new right column is
      // (two rows up, one row up, current pixel).
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]     = win_q[3*i+1];
        win_d[3*i + 1] = win_q[3*i+2];
      end
      win_d[2] = tap2;
      win_d[5] = tap1;
      win_d[8] = pix_in;
    end
  end

  // Control and window registers; reset wins over a simultaneous pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      done_arm_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      done_arm_q   <= done_arm_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line-delay update: the old line1 entry cascades into line2.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      line1_mem[pix_col] <= pix_in;
      line2_mem[pix_col] <= tap1;
    end
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_pack
      assign win_out[gi*NUM_BITS +: NUM_BITS] = win_q[gi];
    end
  endgenerate

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef WIN_COORD_EN
  logic [COL_BITS-1:0] col_out_q, col_out_d;
  logic [ROW_BITS-1:0] row_out_q, row_out_d;

  // Window-centre coordinates follow each produced window.
  always_comb begin
    col_out_d = col_out_q;
    row_out_d = row_out_q;
    if (win_valid_d) begin
      col_out_d = pix_col - COL_BITS'(1);
      row_out_d = pix_row - ROW_BITS'(1);
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_out_q <= '0;
      row_out_q <= '0;
    end else begin
      col_out_q <= col_out_d;
      row_out_q <= row_out_d;
    end
  end

  assign col_out = col_out_q;
  assign row_out = row_out_q;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with a 4x4 frame, pixel value 4*r+c.
module tb_line_window_3x3;
  localparam int NB = 8;
  localparam int LW = 4;
  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            pix_valid;
  logic            sof;
  logic [NB-1:0]   pix_in;
  logic            win_valid;
  logic [9*NB-1:0] win_out;
  logic            frame_done;
`ifdef WIN_COORD_EN
  logic [8:0]      col_out;
  logic [7:0]      row_out;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  line_window_3x3 #(
    .NUM_BITS(NB), .LINE_WIDTH(LW), .NUM_LINES(NL), .COL_BITS(9), .ROW_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
    .win_valid(win_valid), .win_out(win_out), .frame_done(frame_done)
`ifdef WIN_COORD_EN
    , .col_out(col_out), .row_out(row_out)
`endif
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic s, input logic [NB-1:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Expected window for accepted pixel (r,c): element 3*i+j = pixel (r-2+i, c-2+j).
  function automatic logic [9*NB-1:0] exp_win(input int r, input int c);
    logic [9*NB-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*NB +: NB] = NB'(4*(r-2+i) + (c-2+j));
    return w;
  endfunction

  // Full frame with sof on pixel 0 and `gap` idle cycles between pixels.
  task automatic run_frame(input int gap, input string tag);
    int pulses;
    int r;
    int c;
    logic ev;
    logic [9*NB-1:0] held;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      r = k / 4;
      c = k % 4;
      step(1'b1, k == 0, NB'(k));
      ev = (r >= 2) && (c >= 2);
      $display("%s px%0d (%0d,%0d) win_valid=%b frame_done=%b win_out=%h",
               tag, k, r, c, win_valid, frame_done, win_out);
      assert_cnt++;
      if (win_valid !== ev) begin
        fail_cnt++;
        $display("FAIL %s_win_valid px%0d: got %b want %b", tag, k, win_valid, ev);
      end
      assert_cnt++;
      if (frame_done !== 1'b0) begin
        fail_cnt++;
        $display("FAIL %s_early_done px%0d: got %b want 0", tag, k, frame_done);
      end
      if (ev) begin
        pulses++;
        assert_cnt++;
        if (win_out !== exp_win(r, c)) begin
          fail_cnt++;
          $display("FAIL %s_win_out px%0d: got %h want %h", tag, k, win_out, exp_win(r, c));
        end
`ifdef WIN_COORD_EN
        assert_cnt++;
        if (col_out !== 9'(c-1) || row_out !== 8'(r-1)) begin
          fail_cnt++;
          $display("FAIL %s_coord px%0d: got (%0d,%0d) want (%0d,%0d)",
                   tag, k, col_out, row_out, c-1, r-1);
        end
`endif
      end
      held = win_out;
      for (int g = 0; g < gap && k < 15; g++) begin
        step(1'b0, 1'b0, '0);
        assert_cnt++;
        if (win_valid !== 1'b0 || win_out !== held || frame_done !== 1'b0) begin
          fail_cnt++;
          $display("FAIL %s_idle px%0d: got v=%b done=%b out=%h want v=0 done=0 out=%h",
                   tag, k, win_valid, frame_done, win_out, held);
        end
      end
    end
    step(1'b0, 1'b0, '0);
    $display("%s end+1 win_valid=%b frame_done=%b", tag, win_valid, frame_done);
    assert_cnt++;
    if (frame_done !== 1'b1 || win_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL %s_frame_done: got done=%b v=%b want done=1 v=0", tag, frame_done, win_valid);
    end
    step(1'b0, 1'b0, '0);
    assert_cnt++;
    if (frame_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL %s_done_width: got %b want 0", tag, frame_done);
    end
    assert_cnt++;
    if (pulses != 4) begin
      fail_cnt++;
      $display("FAIL %s_pulse_count: got %0d want 4", tag, pulses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 8'hAA);
    step(1'b0, 1'b0, '0);
    reset = 1'b0;
    $display("reset win_valid=%b win_out=%h frame_done=%b", win_valid, win_out, frame_done);
    assert_cnt++;
    if (win_valid !== 1'b0 || win_out !== '0 || frame_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_state: got v=%b out=%h done=%b want 0/0/0", win_valid, win_out, frame_done);
    end
`ifdef WIN_COORD_EN
    assert_cnt++;
    if (col_out !== '0 || row_out !== '0) begin
      fail_cnt++;
      $display("FAIL reset_coord: got (%0d,%0d) want (0,0)", col_out, row_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    run_frame(0, "b2b");
  endtask

  task automatic test_gapped();
    run_frame(1, "gap");
  endtask

  task automatic test_no_sof();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, NB'(k));
      $display("nosof px%0d win_valid=%b frame_done=%b", k, win_valid, frame_done);
      assert_cnt++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
        fail_cnt++;
        $display("FAIL nosof px%0d: got v=%b done=%b want 0/0", k, win_valid, frame_done);
      end
    end
    run_frame(0, "after_nosof");
  endtask

  task automatic test_restart();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, k == 0, NB'(100 + k));
      $display("abort px%0d win_valid=%b frame_done=%b", k, win_valid, frame_done);
      assert_cnt++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
        fail_cnt++;
        $display("FAIL abort px%0d: got v=%b done=%b want 0/0", k, win_valid, frame_done);
      end
    end
    run_frame(0, "restart");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, k == 0, NB'(k));
    end
    reset = 1'b1;
    step(1'b1, 1'b0, 8'd12);
    reset = 1'b0;
    $display("midreset win_valid=%b win_out=%h frame_done=%b", win_valid, win_out, frame_done);
    assert_cnt++;
    if (win_valid !== 1'b0 || win_out !== '0 || frame_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midreset_outputs: got v=%b out=%h done=%b want 0/0/0", win_valid, win_out, frame_done);
    end
    for (int k = 13; k < 20; k++) begin
      step(k < 16, 1'b0, NB'(k));
      $display("postreset px%0d win_valid=%b frame_done=%b", k, win_valid, frame_done);
      assert_cnt++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_out !== '0) begin
        fail_cnt++;
        $display("FAIL postreset px%0d: got v=%b done=%b out=%h want 0/0/0", k, win_valid, frame_done, win_out);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_no_sof();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
